// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file port.
interface rf_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [31:0] pend_mask;

  modport master (
    output a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    input  a_ready, b_ready, rf_waddr, rf_wdata, rf_we, pend_mask
  );

  modport slave (
    input  a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    output a_ready, b_ready, rf_waddr, rf_wdata, rf_we, pend_mask
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter: per-requester FIFOs,
// round-robin grant, registered output stage and a pending-write mask.
module rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  rf_wb_arbiter_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_e;

  // Index 0 is requester A, index 1 is requester B; entries are {waddr, wdata}.
  logic [36:0]   r_mem [2][DEPTH];
  logic [AW-1:0] r_wp [2];
  logic [AW-1:0] r_rp [2];
  logic [AW:0]   r_cnt [2];
  logic [AW:0]   w_cnt_nxt [2];
  logic [1:0]    r_rdy;
  logic [36:0]   w_in [2];
  logic [1:0]    w_push;
  logic [1:0]    w_grant;
  logic [1:0]    w_nonempty;
  logic [36:0]   w_head;
  gnt_e          r_last;
  gnt_e          w_last_nxt;
  logic          r_out_vld;
  logic          r_rf_we;
  logic [4:0]    r_out_waddr;
  logic [31:0]   r_out_wdata;
  logic [31:0]   w_pend;
  logic [AW-1:0] w_off;

  // Gather requester inputs and qualify pushes with the registered ready.
  always_comb begin
    w_in[0]    = {bus.a_waddr, bus.a_wdata};
    w_in[1]    = {bus.b_waddr, bus.b_wdata};
    w_push[0]  = bus.a_valid && r_rdy[0] && !flush;
    w_push[1]  = bus.b_valid && r_rdy[1] && !flush;
    w_nonempty = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      w_nonempty[r] = (r_cnt[r] != '0);
    end
  end

  // Last-grant state register; reset leaves B as last so the first tie goes to A.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_last <= GNT_B;
    else          r_last <= w_last_nxt;
  end

  // Grant selection: sole non-empty FIFO wins, ties alternate away from last grant.
  always_comb begin
    w_grant    = '0;
    w_last_nxt = r_last;
    if (!flush) begin
      if (w_nonempty[0] && (!w_nonempty[1] || r_last == GNT_B)) begin
        w_grant[0] = 1'b1;
        w_last_nxt = GNT_A;
      end else if (w_nonempty[1]) begin
        w_grant[1] = 1'b1;
        w_last_nxt = GNT_B;
      end
    end
    w_head = w_grant[1] ? r_mem[1][r_rp[1]] : r_mem[0][r_rp[0]];
  end

  // Next occupancy per FIFO; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    for (int unsigned r = 0; r < 2; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      unique case ({w_push[r], w_grant[r]})
        2'b10:   w_cnt_nxt[r] = r_cnt[r] + 1'b1;
        2'b01:   w_cnt_nxt[r] = r_cnt[r] - 1'b1;
        default: w_cnt_nxt[r] = r_cnt[r];
      endcase
      if (flush) w_cnt_nxt[r] = '0;
    end
  end

  // FIFO pointers, counts and registered ready (held low for one cycle after a flush).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < 2; r++) begin
        r_wp[r]  <= '0;
        r_rp[r]  <= '0;
        r_cnt[r] <= '0;
      end
      r_rdy <= '0;
    end else begin
      for (int unsigned r = 0; r < 2; r++) begin
        if (flush) begin
          r_wp[r] <= '0;
          r_rp[r] <= '0;
        end else begin
          if (w_push[r])  r_wp[r] <= r_wp[r] + 1'b1;
          if (w_grant[r]) r_rp[r] <= r_rp[r] + 1'b1;
        end
        r_cnt[r] <= w_cnt_nxt[r];
        r_rdy[r] <= !flush && (w_cnt_nxt[r] != FULL_CNT);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < 2; r++) begin
      if (w_push[r]) r_mem[r][r_wp[r]] <= w_in[r];
    end
  end

  // Output stage: load the granted head; waddr 0 stages but never writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_vld   <= 1'b0;
      r_rf_we     <= 1'b0;
      r_out_waddr <= '0;
      r_out_wdata <= '0;
    end else if (w_grant != '0) begin
      r_out_vld   <= 1'b1;
      r_rf_we     <= (w_head[36:32] != '0);
      r_out_waddr <= w_head[36:32];
      r_out_wdata <= w_head[31:0];
    end else begin
      r_out_vld <= 1'b0;
      r_rf_we   <= 1'b0;
    end
  end

  // Pending mask over occupied FIFO slots plus the staged entry; bit 0 never set.
  always_comb begin
    w_pend = '0;
    w_off  = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_off = AW'(i) - r_rp[r];
        if ({1'b0, w_off} < r_cnt[r]) w_pend[r_mem[r][i][36:32]] = 1'b1;
      end
    end
    if (r_out_vld) w_pend[r_out_waddr] = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign bus.a_ready   = r_rdy[0];
  assign bus.b_ready   = r_rdy[1];
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_waddr  = r_out_waddr;
  assign bus.rf_wdata  = r_out_wdata;
  assign bus.pend_mask = w_pend;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against
// a queue-based reference model of the writeback path.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [36:0] qa[$];
  logic [36:0] qb[$];
  bit          m_last;   // 0 = A granted last, 1 = B
  logic [4:0]  m_sa;
  logic [31:0] m_sd;
  bit          m_svld, m_we, m_ardy, m_brdy, m_acc_a, m_acc_b;

  logic [36:0] src_a[$];
  logic [36:0] src_b[$];
  logic [4:0]  out_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_last = 1'b1;
    m_svld = 1'b0;
    m_we   = 1'b0;
    m_sa   = '0;
    m_sd   = '0;
    m_ardy = 1'b0;
    m_brdy = 1'b0;
  endtask

  function automatic logic [31:0] exp_pend();
    logic [31:0] p;
    p = '0;
    foreach (qa[i]) p[qa[i][36:32]] = 1'b1;
    foreach (qb[i]) p[qb[i][36:32]] = 1'b1;
    if (m_svld) p[m_sa] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock edge of the writeback path, applied to the model's pre-edge state.
  task automatic model_edge();
    bit ne_a, ne_b, gv;
    logic [36:0] g;
    ne_a = (qa.size() != 0);
    ne_b = (qb.size() != 0);
    gv = 1'b0;
    g = '0;
    m_acc_a = 1'b0;
    m_acc_b = 1'b0;
    if (flush) begin
      qa.delete();
      qb.delete();
      m_svld = 1'b0;
      m_we   = 1'b0;
      m_ardy = 1'b0;
      m_brdy = 1'b0;
    end else begin
      if (ne_a && (!ne_b || m_last)) begin
        g = qa.pop_front(); gv = 1'b1; m_last = 1'b0;
      end else if (ne_b) begin
        g = qb.pop_front(); gv = 1'b1; m_last = 1'b1;
      end
      m_svld = gv;
      m_we   = gv && (g[36:32] != 5'd0);
      if (gv) begin
        m_sa = g[36:32];
        m_sd = g[31:0];
      end
      if (bus.a_valid && m_ardy) begin
        qa.push_back({bus.a_waddr, bus.a_wdata}); m_acc_a = 1'b1;
      end
      if (bus.b_valid && m_brdy) begin
        qb.push_back({bus.b_waddr, bus.b_wdata}); m_acc_b = 1'b1;
      end
      m_ardy = (qa.size() < DEPTH);
      m_brdy = (qb.size() < DEPTH);
    end
  endtask

  task automatic check_all();
    chk("rf_we", {31'b0, bus.rf_we}, {31'b0, m_we});
    chk("rf_waddr", {27'b0, bus.rf_waddr}, {27'b0, m_sa});
    chk("rf_wdata", bus.rf_wdata, m_sd);
    chk("pend_mask", bus.pend_mask, exp_pend());
    chk("a_ready", {31'b0, bus.a_ready}, {31'b0, m_ardy});
    chk("b_ready", {31'b0, bus.b_ready}, {31'b0, m_brdy});
    if (bus.rf_we) out_log.push_back(bus.rf_waddr);
  endtask

  task automatic cyc(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                     input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                     input bit fl);
    bus.a_valid = av; bus.a_waddr = aa; bus.a_wdata = ad;
    bus.b_valid = bv; bus.b_waddr = ba; bus.b_wdata = bd;
    flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, 0);
  endtask

  // Offer src_a/src_b entries, holding each until accepted.
  task automatic drive_src(input int ncyc);
    logic [36:0] ea, eb;
    for (int c = 0; c < ncyc; c++) begin
      ea = (src_a.size() != 0) ? src_a[0] : '0;
      eb = (src_b.size() != 0) ? src_b[0] : '0;
      cyc(src_a.size() != 0, ea[36:32], ea[31:0], src_b.size() != 0, eb[36:32], eb[31:0], 0);
      if (m_acc_a) void'(src_a.pop_front());
      if (m_acc_b) void'(src_b.pop_front());
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    flush = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit ra_v, rb_v;
    logic [4:0] ra_a, rb_a;
    logic [31:0] ra_d, rb_d;
    logic [4:0] exp30 [6];

    bus.a_valid = 0; bus.a_waddr = '0; bus.a_wdata = '0;
    bus.b_valid = 0; bus.b_waddr = '0; bus.b_wdata = '0;
    model_reset();
    do_reset();

    // Single write from A: staged one cycle after the push edge.
    idle(1);
    cyc(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0);
    chk("p29_pend_e0", bus.pend_mask, 32'h20);
    chk("p29_we_e0", {31'b0, bus.rf_we}, 32'd0);
    idle(1);
    chk("p29_we_e1", {31'b0, bus.rf_we}, 32'd1);
    chk("p29_addr_e1", {27'b0, bus.rf_waddr}, 32'd5);
    chk("p29_data_e1", bus.rf_wdata, 32'hDEADBEEF);
    chk("p29_pend_e1", bus.pend_mask, 32'h20);
    idle(1);
    chk("p29_we_e2", {31'b0, bus.rf_we}, 32'd0);
    chk("p29_pend_e2", bus.pend_mask, 32'h0);

    // Interleaving of two continuous streams after a fresh reset.
    do_reset();
    idle(1);
    out_log.delete();
    for (int i = 1; i <= 3; i++) begin
      src_a.push_back({5'(i), 32'(i * 16)});
      src_b.push_back({5'(i + 10), 32'(i * 256)});
    end
    drive_src(10);
    exp30 = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
    chk("p30_count", out_log.size(), 32'd6);
    foreach (exp30[i]) chk("p30_order", (i < out_log.size()) ? {27'b0, out_log[i]} : 32'hFFFF_FFFF, {27'b0, exp30[i]});

    // DEPTH+1 writes from A alone: all appear, in order.
    out_log.delete();
    for (int i = 0; i <= DEPTH; i++) src_a.push_back({5'(20 + i), 32'(i)});
    drive_src(DEPTH + 6);
    chk("p31_count", out_log.size(), DEPTH + 1);
    for (int i = 0; i <= DEPTH; i++)
      chk("p31_order", (i < out_log.size()) ? {27'b0, out_log[i]} : 32'hFFFF_FFFF, 32'(20 + i));

    // waddr 0 consumes a slot without writing.
    out_log.delete();
    src_a.push_back({5'd0, 32'h1});
    src_a.push_back({5'd7, 32'h7});
    drive_src(2);
    chk("p32_we0", {31'b0, bus.rf_we}, 32'd0);
    idle(1);
    chk("p32_we7", {31'b0, bus.rf_we}, 32'd1);
    chk("p32_addr7", {27'b0, bus.rf_waddr}, 32'd7);
    idle(2);

    // Flush with both FIFOs occupied.
    for (int i = 0; i < 2; i++) begin
      src_a.push_back({5'(3 + i), 32'h0A});
      src_b.push_back({5'(8 + i), 32'h0B});
    end
    drive_src(3);
    out_log.delete();
    cyc(0, '0, '0, 0, '0, '0, 1);
    chk("p33_we", {31'b0, bus.rf_we}, 32'd0);
    chk("p33_pend", bus.pend_mask, 32'd0);
    idle(4);
    chk("p33_none_after", out_log.size(), 32'd0);

    // Reset between edges with a staged write.
    cyc(1, 5'd9, 32'h99, 0, '0, '0, 0);
    idle(1);
    chk("p34_staged", {31'b0, bus.rf_we}, 32'd1);
    out_log.delete();
    do_reset();
    idle(3);
    chk("p34_no_write", out_log.size(), 32'd0);

    // Randomized traffic with hold-until-accepted requesters.
    ra_v = 0; rb_v = 0; ra_a = '0; rb_a = '0; ra_d = '0; rb_d = '0;
    for (int c = 0; c < 800; c++) begin
      if (!ra_v && $urandom_range(99) < 60) begin
        ra_v = 1; ra_a = 5'($urandom_range(31)); ra_d = $urandom;
      end
      if (!rb_v && $urandom_range(99) < 60) begin
        rb_v = 1; rb_a = 5'($urandom_range(31)); rb_d = $urandom;
      end
      if (c == 400) do_reset();
      cyc(ra_v, ra_a, ra_d, rb_v, rb_a, rb_d, $urandom_range(99) < 3);
      if (m_acc_a) ra_v = 0;
      if (m_acc_b) rb_v = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, per-requester queue depth in entries (legal 2..8, power of two).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1, synchronous discard of all queued and staged writes.
REQ-005 The block SHALL have ports a_valid (input, 1), a_ready (output, 1), a_waddr (input, 5) and a_wdata (input, 32), forming writeback requester A.
REQ-006 The block SHALL have ports b_valid (input, 1), b_ready (output, 1), b_waddr (input, 5) and b_wdata (input, 32), forming writeback requester B.
REQ-007 The block SHALL have ports rf_waddr (output, 5), rf_wdata (output, 32) and rf_we (output, 1), which drive the register file write port.
REQ-008 The block SHALL have port pend_mask, output, 32, where bit i is set when a write to register i is queued or staged.

Function
REQ-009 The block SHALL keep one FIFO of DEPTH entries per requester; each entry holds {waddr, wdata}.
REQ-010 The block SHALL register a_ready as !full(A) and b_ready as !full(B), independent of the same-cycle pop.
REQ-011 The block SHALL push an entry on an edge where valid && ready is true; valid with ready low is held by the requester and SHALL NOT be lost.
REQ-012 The block SHALL have an arbiter that grants at most one FIFO head per cycle; a grant pops that head on the same edge and loads the output stage.
REQ-013 When only one FIFO is non-empty, the arbiter SHALL grant that FIFO.
REQ-014 When both FIFOs are non-empty, the arbiter SHALL use round-robin: it grants the requester not granted last; last_grant updates only on a grant.
REQ-015 The output stage SHALL be a register; rf_we SHALL be 1 in the cycle after a grant edge iff the granted waddr != 0; rf_waddr and rf_wdata SHALL hold the granted entry.
REQ-016 An entry with waddr == 0 SHALL be accepted, arbitrated and popped (it consumes a slot), but SHALL produce rf_we = 0.
REQ-017 rf_we SHALL be 0 in any cycle not preceded by a grant; rf_waddr and rf_wdata SHALL hold their last values when rf_we is 0.
REQ-018 Latency: a push at edge E0 SHALL give rf_we = 1 no earlier than the cycle after edge E1; the register file updates at edge E2.
REQ-019 Throughput: one write per cycle is sustained while any FIFO is non-empty.
REQ-020 Within one requester, writes SHALL reach the port in push order; the block makes no ordering guarantee between A and B.
REQ-021 pend_mask bit i (i != 0) SHALL be the OR over all valid FIFO entries and the valid output-stage entry having waddr == i; bit 0 SHALL always be 0. It is combinational from state.
REQ-022 When a push and a pop occur on the same FIFO in the same edge, the FIFO SHALL leave its count unchanged and preserve order; this is legal only when the FIFO is not full.
REQ-023 Pointer wrap-around SHALL be modulo DEPTH, with no entry loss or duplication.
REQ-024 When flush = 1 at an edge, the block SHALL empty both FIFOs, clear the output-stage valid bit and ignore pushes and grants; rf_we and pend_mask SHALL be 0 in the following cycle.
REQ-025 a_ready and b_ready SHALL be 0 in the cycle after a flush edge, and 1 from the next cycle on.

Reset
REQ-026 Assertion of reset_n = 0 SHALL immediately, without waiting for clk, force: FIFOs empty, output-stage valid = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, pend_mask = 0, a_ready = 0, b_ready = 0, last_grant = B.
REQ-027 Reset asserted mid-operation SHALL discard all queued and staged writes; no partial write shall reach the port.
REQ-028 After deassertion, a_ready and b_ready SHALL become 1 at the first clk edge; the first tie goes to A.

Verification
REQ-029 A single push of A (waddr = 5, wdata = 0xDEADBEEF) at edge 0 SHALL give rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF during the cycle after edge 1 only, and pend_mask = 0x20 from after edge 0 until after edge 2.
REQ-030 Continuous pushes from A and B (A: 1, 2, 3; B: 11, 12, 13) after reset SHALL produce the rf_waddr sequence 1, 11, 2, 12, 3, 13 with rf_we = 1 every cycle.
REQ-031 A filled to DEPTH with B idle SHALL drive a_ready = 0 for exactly one cycle at full; all DEPTH+1 offered writes SHALL emerge in order, with none lost.
REQ-032 A push of A with waddr = 0 (wdata = 0x1) followed by waddr = 7 SHALL give rf_we = 0 in the first output cycle and rf_we = 1 with rf_waddr = 7 in the next; pend_mask bit 0 SHALL never be set.
REQ-033 A flush with 2 entries in each FIFO SHALL give rf_we = 0 and pend_mask = 0 in the next cycle, and no queued write shall appear afterward.
REQ-034 reset_n driven low between clk edges with an entry staged SHALL drop rf_we to 0 within the same cycle; after release, the register file sees no write from that entry.
